// File: rtl/peak_span_adc_if.sv
// Peak-to-peak ADC window measurement bus.
// Control and sample inputs toward the block, results back.
interface peak_span_adc_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic              continuous;
  logic              hold_mode;
  logic              hold_clr;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              busy;
  logic              result_valid;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] max_out;
  logic [DATA_W-1:0] min_out;
  logic              no_sample;

  modport master (
    output start, abort, continuous,
    output hold_mode, hold_clr,
    output sample_valid, sample,
    input  busy, result_valid, span,
    input  max_out, min_out, no_sample
  );

  modport slave (
    input  start, abort, continuous,
    input  hold_mode, hold_clr,
    input  sample_valid, sample,
    output busy, result_valid, span,
    output max_out, min_out, no_sample
  );
endinterface

// File: rtl/peak_span_adc.sv
// Settle, acquire and report the peak-to-peak span
// of a converter window, with optional max hold.
module peak_span_adc #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8,
  parameter int SETTLE_LEN = 256,
  parameter int ACQ_LEN    = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  peak_span_adc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACQ,
    RESULT
  } state_t;

  // LEN-1 always fits in CNT_W bits, even for LEN = 2^CNT_W
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST =
    CNT_W'(ACQ_LEN - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] min_q;
  logic              seen_q;
  logic [DATA_W-1:0] held_q;
  logic              busy_q;
  logic              rv_q;
  logic [DATA_W-1:0] span_q;
  logic [DATA_W-1:0] max_out_q;
  logic [DATA_W-1:0] min_out_q;
  logic              ns_q;

  logic [DATA_W-1:0] span_now;
  logic [DATA_W-1:0] held_d;
  logic [DATA_W-1:0] span_d;

  // Window span and the hold value it would produce
  always_comb begin
    span_now = seen_q ? (max_q - min_q) : '0;
    held_d   = held_q;
    if (bus.hold_clr)
      held_d = span_now;
    else if (bus.hold_mode && span_now > held_q)
      held_d = span_now;
    span_d = bus.hold_mode ? held_d : span_now;
  end

  // Sequencer with registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      max_q     <= '0;
      min_q     <= '1;
      seen_q    <= 1'b0;
      held_q    <= '0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      span_q    <= '0;
      max_out_q <= '0;
      min_out_q <= '0;
      ns_q      <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (bus.hold_clr && !(bus.abort && busy_q))
        held_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == SET_LAST) begin
            state_q <= ACQ;
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '1;
            seen_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACQ: begin
          if (bus.abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            if (bus.sample_valid) begin
              if (bus.sample > max_q)
                max_q <= bus.sample;
              if (bus.sample < min_q)
                min_q <= bus.sample;
              seen_q <= 1'b1;
            end
            if (cnt_q == ACQ_LAST) begin
              state_q <= RESULT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        RESULT: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            rv_q      <= 1'b1;
            span_q    <= span_d;
            held_q    <= held_d;
            max_out_q <= seen_q ? max_q : '0;
            min_out_q <= seen_q ? min_q : '0;
            ns_q      <= !seen_q;
            if (bus.continuous) begin
              state_q <= SETTLE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
  assign bus.span         = span_q;
  assign bus.max_out      = max_out_q;
  assign bus.min_out      = min_out_q;
  assign bus.no_sample    = ns_q;

endmodule

// File: tb/tb_peak_span_adc.sv
// Directed checks for peak_span_adc with
// SETTLE_LEN=4, ACQ_LEN=8, CNT_W=3.
module tb_peak_span_adc;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  peak_span_adc_if #(.DATA_W(8)) bus ();

  peak_span_adc #(
    .DATA_W    (8),
    .CNT_W     (3),
    .SETTLE_LEN(4),
    .ACQ_LEN   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs for cycle n after start (ACQ = 5..12)
  task automatic drv(
    input int          n,
    input logic [63:0] s,
    input logic [7:0]  v
  );
    if (n >= 5 && n <= 12) begin
      bus.sample_valid = v[n-5];
      bus.sample       = s[(n-5)*8 +: 8];
    end else begin
      bus.sample_valid = 1'b0;
      bus.sample       = 8'd0;
    end
  endtask

  task automatic conv(
    input  logic [63:0] s,
    input  logic [7:0]  v,
    output int          lat
  );
    bus.start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      tick();
      bus.start = 1'b0;
      drv(n, s, v);
      if (bus.result_valid)
        lat = n;
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic chk_res(
    input string      tag,
    input logic [7:0] sp,
    input logic [7:0] mx,
    input logic [7:0] mn,
    input logic       ns
  );
    chk({tag, "_span"}, bus.span, sp);
    chk({tag, "_max"}, bus.max_out, mx);
    chk({tag, "_min"}, bus.min_out, mn);
    chk({tag, "_ns"}, bus.no_sample, ns);
  endtask

  initial begin
    int lat;
    int bad;
    int bl;
    checks = 0;
    errors = 0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.continuous   = 1'b0;
    bus.hold_mode    = 1'b0;
    bus.hold_clr     = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample       = 8'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk_res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Basic window: 10,200,50,3
    conv(64'h0000_0000_0332_C80A, 8'b0000_1111, lat);
    chk("basic_lat", lat, 14);
    chk("basic_busy", bus.busy, 0);
    chk_res("basic", 197, 200, 3, 0);
    tick();
    chk("basic_pulse", bus.result_valid, 0);
    chk("basic_holdout", bus.span, 197);

    // Empty window
    conv(64'h0, 8'b0, lat);
    chk("empty_lat", lat, 14);
    chk_res("empty", 0, 0, 0, 1);

    // First and last ACQ cycle samples
    conv(64'h1400_0000_0000_0064, 8'b1000_0001, lat);
    chk("edge_lat", lat, 14);
    chk_res("edge", 80, 100, 20, 0);

    // Hold mode
    bus.hold_mode = 1'b1;
    conv(64'h3296, 8'b11, lat);
    chk_res("hold1", 100, 150, 50, 0);
    conv(64'h143C, 8'b11, lat);
    chk_res("hold2", 100, 60, 20, 0);
    bus.hold_clr = 1'b1;
    tick();
    bus.hold_clr = 1'b0;
    conv(64'h143C, 8'b11, lat);
    chk_res("hold3", 40, 60, 20, 0);
    bus.hold_mode = 1'b0;
    tick();

    // Abort in 3rd ACQ cycle
    bus.start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      bus.start = 1'b0;
      drv(n, 64'hFF01_FF01_FF01_FF01, 8'hFF);
    end
    chk("abort_busy_pre", bus.busy, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.sample_valid = 1'b0;
    chk("abort_busy", bus.busy, 0);
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      if (bus.result_valid || bus.busy)
        bad++;
      tick();
    end
    chk("abort_norv", bad, 0);
    chk_res("abort", 40, 60, 20, 0);

    // Continuous, 255 during SETTLE excluded
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    bad = 0;
    bl = 0;
    for (int n = 1; n <= 27; n++) begin
      int p;
      int c;
      tick();
      bus.start = 1'b0;
      p = (n - 1) % 13;
      c = (n - 1) / 13;
      if (!bus.busy)
        bl++;
      if (bus.result_valid) begin
        if (n == 14)
          chk_res("cont1", 60, 90, 30, 0);
        else if (n == 27)
          chk_res("cont2", 245, 250, 5, 0);
        else
          bad++;
      end else if (n == 14 || n == 27) begin
        bad++;
      end
      if (p < 4) begin
        bus.sample_valid = 1'b1;
        bus.sample       = 8'd255;
      end else if (c == 0) begin
        drv(p + 1, 64'h5A1E, 8'b0000_0011);
      end else begin
        drv(p + 1, 64'h0000_FA00_0005_0000,
            8'b0010_0100);
      end
    end
    chk("cont_busy_low", bl, 0);
    chk("cont_rv_timing", bad, 0);
    bus.continuous = 1'b0;
    bus.sample_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("cont_stop_busy", bus.busy, 0);

    // Reset during ACQ
    bus.start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      bus.start = 1'b0;
      drv(n, 64'h01FA, 8'b11);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_rv", bus.result_valid, 0);
    chk_res("arst", 0, 0, 0, 0);
    bus.sample_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (bus.result_valid || bus.busy)
        bad++;
    end
    chk("arst_quiet", bad, 0);
    conv(64'h3C28, 8'b11, lat);
    chk("post_lat", lat, 14);
    chk_res("post", 20, 60, 40, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_span_adc.md
PEAK_SPAN_ADC -- requirements
Module: peak_span_adc

Interface
REQ-001 Parameter DATA_W, default 8: sample and result width in bits, 2 to 16.
REQ-002 Parameter CNT_W, default 8: phase counter width in bits.
REQ-003 Parameter SETTLE_LEN, default 256: settle phase length in clock cycles, 1 to 2^CNT_W.
REQ-004 Parameter ACQ_LEN, default 256: acquisition phase length in clock cycles, 1 to 2^CNT_W.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  begin a conversion; sampled in IDLE only.
REQ-009 abort  in  1  synchronous cancel of a running conversion.
REQ-010 continuous  in  1  when 1, RESULT re-enters SETTLE instead of IDLE.
REQ-011 hold_mode  in  1  when 1, span reports the running maximum span.
REQ-012 hold_clr  in  1  clears the held maximum span.
REQ-013 sample_valid  in  1  qualifies sample.
REQ-014 sample  in  DATA_W  unsigned converter code.
REQ-015 busy  out  1  high in SETTLE, ACQ and RESULT.
REQ-016 result_valid  out  1  one-cycle pulse; span, max_out, min_out and no_sample are new in that cycle.
REQ-017 span  out  DATA_W  peak-to-peak result.
REQ-018 max_out  out  DATA_W  window maximum.
REQ-019 min_out  out  DATA_W  window minimum.
REQ-020 no_sample  out  1  last window contained no valid sample.

Function
REQ-021 FSM states: IDLE, SETTLE, ACQ, RESULT; all outputs registered.
REQ-022 IDLE with start=1 and abort=0 -> SETTLE with cnt=0; start is ignored in every other state.
REQ-023 SETTLE counts exactly SETTLE_LEN cycles and ignores samples, then -> ACQ with cnt=0, max_r=0, min_r=all ones, seen=0.
REQ-024 ACQ lasts exactly ACQ_LEN cycles whatever sample_valid does.
REQ-025 In each ACQ cycle with sample_valid=1: max_r=max(max_r,sample), min_r=min(min_r,sample), seen=1; the last ACQ cycle's sample is included.
REQ-026 RESULT lasts one cycle; span_now=max_r-min_r, never negative; when seen=0: span_now=0, max_out=0, min_out=0 and no_sample=1.
REQ-027 hold_mode=0: span=span_now; hold_mode=1: held=max(held,span_now) and span=the updated held value.
REQ-028 hold_clr=1 sets held=0 on that edge; if it coincides with RESULT, held=span_now.
REQ-029 result_valid rises on the edge leaving RESULT and lasts one cycle; result outputs hold their values until the next result_valid.
REQ-030 Latency: result_valid is high SETTLE_LEN+ACQ_LEN+2 cycles after the cycle in which start was sampled.
REQ-031 RESULT -> SETTLE if continuous=1, else -> IDLE; busy is low during the result_valid cycle unless continuous=1.
REQ-032 abort=1 in SETTLE, ACQ or RESULT -> IDLE on the next edge, with no result_valid, and span, max_out, min_out and held unchanged; abort has priority over start and continuous.
REQ-033 Counter terminal compare uses LEN-1 and must be correct when LEN=2^CNT_W.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, cnt=0, busy=0, result_valid=0, span=0, max_out=0, min_out=0, no_sample=0, held=0, max_r=0 and min_r=all ones.
REQ-035 Reset asserted mid-conversion discards the conversion; no result_valid follows reset release until a new start.

Verification (DATA_W=8, SETTLE_LEN=4, ACQ_LEN=8)
REQ-036 Pulse start with samples 10,200,50,3 valid in ACQ -> result_valid in cycle 14, span=197, max_out=200, min_out=3, no_sample=0.
REQ-037 sample_valid=0 for the whole window -> span=0, max_out=0, min_out=0, no_sample=1.
REQ-038 hold_mode=1 with window spans 100 then 40 -> span=100, 100; then hold_clr plus a 40-span window -> span=40.
REQ-039 abort in the 3rd ACQ cycle -> IDLE next cycle, busy=0, no result_valid, prior outputs unchanged.
REQ-040 continuous=1 -> result_valid every 13 cycles and busy stays high; samples of 255 in the SETTLE phase are excluded from the results.
REQ-041 rst_n low during ACQ -> all outputs 0 at once; after release, a new start gives a correct result with no stale extrema.
